// File: rtl/aes_fifo_pkg.sv
// Shared constants and width helper for the AES data-path FIFOs.
package aes_fifo_pkg;

  localparam int unsigned DEF_DATA_WH = 32;
  localparam int unsigned DEF_DEPTH   = 4;

  // Bits needed to index n entries, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w = w + 1;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/aes_fifo_if.sv
// FIFO push/pop/status bundle; master drives requests, slave is the FIFO.
interface aes_fifo_if
  import aes_fifo_pkg::*;
#(
  parameter int unsigned DATA_WH = DEF_DATA_WH,
  parameter int unsigned DEPTH   = DEF_DEPTH
);
  localparam int unsigned CNT_WH = $clog2(DEPTH + 1);

  logic               flush;
  logic               clr_err;
  logic               write_fifo;
  logic [DATA_WH-1:0] data_in;
  logic               read_fifo;
  logic [DATA_WH-1:0] data_out;
  logic               empty_fifo;
  logic               full_fifo;
  logic               almost_full;
  logic               almost_empty;
  logic [CNT_WH-1:0]  counter_fifo;
  logic               overflow;
  logic               underflow;

  modport master (
    output flush, clr_err, write_fifo, data_in, read_fifo,
    input  data_out, empty_fifo, full_fifo, almost_full, almost_empty,
           counter_fifo, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, write_fifo, data_in, read_fifo,
    output data_out, empty_fifo, full_fifo, almost_full, almost_empty,
           counter_fifo, overflow, underflow
  );

endinterface

// File: rtl/aes_fifo_mem.sv
// DEPTH x DATA_WH register array: synchronous write, asynchronous read.
module aes_fifo_mem
  import aes_fifo_pkg::*;
#(
  parameter int unsigned DATA_WH = DEF_DATA_WH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned AW      = clog2_min1(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [DATA_WH-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [DATA_WH-1:0] rdata
);

  logic [DATA_WH-1:0] mem [DEPTH];

  // Contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aes_fifo_sync.sv
// First-word-fall-through synchronous FIFO with programmable level flags,
// flush and sticky overflow/underflow errors.
module aes_fifo_sync
  import aes_fifo_pkg::*;
#(
  parameter int unsigned DATA_WH   = DEF_DATA_WH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AFULL_TH  = 3,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic       clk,
  input  logic       reset,
  aes_fifo_if.slave  bus
);

  localparam int unsigned AW     = clog2_min1(DEPTH);
  localparam int unsigned CNT_WH = $clog2(DEPTH + 1);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_WH-1:0] count;
  logic              overflow;
  logic              underflow;

  logic              rd_acc;
  logic              wr_acc;
  logic              empty;
  logic              full;
  logic              mem_we;

  assign empty  = (count == '0);
  assign full   = (count == CNT_WH'(DEPTH));

  // Read needs data already stored; a write at full is allowed if a pop frees a slot.
  assign rd_acc = bus.read_fifo & ~empty;
  assign wr_acc = bus.write_fifo & (~full | rd_acc);
  assign mem_we = wr_acc & ~bus.flush & ~reset;

  aes_fifo_mem #(
    .DATA_WH (DATA_WH),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  // Pointers and occupancy; flush discards contents but leaves errors alone.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_WH'(1);
        2'b01:   count <= count - CNT_WH'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors; a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      overflow  <= overflow  & ~bus.clr_err;
      underflow <= underflow & ~bus.clr_err;
    end else begin
      overflow  <= (overflow  & ~bus.clr_err) | (bus.write_fifo & ~wr_acc);
      underflow <= (underflow & ~bus.clr_err) | (bus.read_fifo  & ~rd_acc);
    end
  end

  assign bus.counter_fifo = count;
  assign bus.empty_fifo   = empty;
  assign bus.full_fifo    = full;
  assign bus.almost_full  = (count >= CNT_WH'(AFULL_TH));
  assign bus.almost_empty = (count <= CNT_WH'(AEMPTY_TH));
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
